// File: rtl/network_idle_detector.sv
// rtl/network_idle_detector.sv - quiescence detector for a dataflow network of actor triggers
// Optional statistics outputs (fire_count, quiesce_count) are built when NETWORK_IDLE_STATS_EN is defined.
module network_idle_detector #(
  parameter int NUM_ACTORS = 4,
  parameter int HOLDOFF    = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic [NUM_ACTORS-1:0] actor_done,
  input  logic [NUM_ACTORS-1:0] actor_executed,
  output logic                  network_idle,
  output logic [NUM_ACTORS-1:0] quiet_mask
`ifdef NETWORK_IDLE_STATS_EN
  ,
  output logic [31:0]           fire_count,
  output logic [15:0]           quiesce_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TRACKING  = 2'd1,
    S_QUIESCENT = 2'd2
  } state_t;

  localparam logic [7:0] HOLD = 8'(HOLDOFF);

  state_t                  state, state_d;
  logic [NUM_ACTORS-1:0]   mask_d;
  logic [7:0]              count, count_d;
  logic                    idle_d;
  logic                    fire;
  logic [NUM_ACTORS-1:0]   quiet_set;
  logic [NUM_ACTORS-1:0]   merged_mask;
  logic                    all_quiet;

  // Classify this cycle's completions; executed bits are masked by done so X is harmless
  always_comb begin
    fire        = |(actor_done & actor_executed);
    quiet_set   = actor_done & ~actor_executed;
    merged_mask = quiet_mask | quiet_set;
    all_quiet   = &merged_mask;
  end

  // State register plus the tracking datapath (mask, hold-off counter, idle flag)
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= S_IDLE;
      quiet_mask   <= '0;
      count        <= '0;
      network_idle <= 1'b0;
    end else begin
      state        <= state_d;
      quiet_mask   <= mask_d;
      count        <= count_d;
      network_idle <= idle_d;
    end
  end

  // Next-state logic: start wins over dones, fire wins over quiet bits.
  // The merged mask is used so the final quiet bit already starts the hold-off;
  // with HOLDOFF=0 the idle flag then rises the cycle right after that bit.
  always_comb begin
    state_d = state;
    mask_d  = quiet_mask;
    count_d = count;
    if (ap_start) begin
      state_d = S_TRACKING;
      mask_d  = '0;
      count_d = '0;
    end else begin
      case (state)
        S_TRACKING: begin
          if (fire) begin
            mask_d  = '0;
            count_d = '0;
          end else begin
            mask_d = merged_mask;
            if (all_quiet) begin
              if (count == HOLD) state_d = S_QUIESCENT;
              else               count_d = count + 8'd1;
            end
          end
        end
        S_QUIESCENT: begin
          if (fire) begin
            state_d = S_TRACKING;
            mask_d  = '0;
            count_d = '0;
          end
        end
        default: begin
          state_d = state;
        end
      endcase
    end
  end

  // Output logic: idle flag is registered from the next state, never from inputs directly
  always_comb begin
    idle_d = (state_d == S_QUIESCENT);
  end

`ifdef NETWORK_IDLE_STATS_EN
  // Saturating statistics, cleared on reset and on every new run
  always_ff @(posedge ap_clk) begin
    if (ap_rst || ap_start) begin
      fire_count    <= '0;
      quiesce_count <= '0;
    end else begin
      if (state != S_IDLE && fire && fire_count != '1)
        fire_count <= fire_count + 32'd1;
      if (state == S_TRACKING && state_d == S_QUIESCENT && quiesce_count != '1)
        quiesce_count <= quiesce_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_network_idle_detector.sv
// tb/tb_network_idle_detector.sv - directed self-checking bench for network_idle_detector
module tb_network_idle_detector;

  logic       ap_clk = 1'b0;
  logic       ap_rst = 1'b1;
  logic       ap_start = 1'b0;
  logic [2:0] actor_done = '0;
  logic [2:0] actor_executed = '0;
  logic       network_idle;
  logic [2:0] quiet_mask;
  logic [2:0] d0_done = '0;
  logic [2:0] d0_exec = '0;
  logic       d0_idle;
  logic [2:0] d0_mask;
`ifdef NETWORK_IDLE_STATS_EN
  logic [31:0] fire_count, d0_fire_count;
  logic [15:0] quiesce_count, d0_quiesce_count;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 ap_clk = ~ap_clk;

  network_idle_detector #(.NUM_ACTORS(3), .HOLDOFF(2)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .actor_done(actor_done), .actor_executed(actor_executed),
    .network_idle(network_idle), .quiet_mask(quiet_mask)
`ifdef NETWORK_IDLE_STATS_EN
    , .fire_count(fire_count), .quiesce_count(quiesce_count)
`endif
  );

  network_idle_detector #(.NUM_ACTORS(3), .HOLDOFF(0)) dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .actor_done(d0_done), .actor_executed(d0_exec),
    .network_idle(d0_idle), .quiet_mask(d0_mask)
`ifdef NETWORK_IDLE_STATS_EN
    , .fire_count(d0_fire_count), .quiesce_count(d0_quiesce_count)
`endif
  );

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] d, input logic [2:0] e);
    actor_done     = d;
    actor_executed = e;
  endtask

  initial begin
    // reset
    step(); step();
    check("rst_idle", network_idle, 0);
    check("rst_mask", quiet_mask, 0);
    ap_rst = 1'b0;

    // dones ignored while IDLE
    drive(3'b111, 3'b000); step();
    drive(3'b111, 3'b111); step();
    drive(3'b000, 3'b000); step();
    check("idle_ign_idle", network_idle, 0);
    check("idle_ign_mask", quiet_mask, 0);

    // start, then quiet bits one per cycle
    ap_start = 1'b1; step(); ap_start = 1'b0;
    check("start_mask", quiet_mask, 0);
`ifdef NETWORK_IDLE_STATS_EN
    check("st_fire0", fire_count, 0);
    check("st_q0", quiesce_count, 0);
`endif
    drive(3'b001, 3'b000); step();
    check("q0_mask", quiet_mask, 3'b001);
    drive(3'b010, 3'b000); step();
    check("q1_mask", quiet_mask, 3'b011);
    drive(3'b100, 3'b000); step();
    check("q2_mask", quiet_mask, 3'b111);
    check("q2_idle", network_idle, 0);
    drive(3'b000, 3'b000); step();
    check("hold1_idle", network_idle, 0);
    step();
    check("hold2_idle", network_idle, 1);

    // quiescent: non-executed done keeps idle; executed done drops it
    drive(3'b010, 3'b000); step();
    check("qsc_quiet_idle", network_idle, 1);
    drive(3'b100, 3'b100); step();
    check("qsc_fire_idle", network_idle, 0);
    check("qsc_fire_mask", quiet_mask, 0);
`ifdef NETWORK_IDLE_STATS_EN
    check("st_fire1", fire_count, 1);
    check("st_q1", quiesce_count, 1);
`endif

    // fire during hold-off cancels, then a full new round is needed
    drive(3'b111, 3'b000); step();
    check("ho_mask", quiet_mask, 3'b111);
    drive(3'b010, 3'b010); step();
    check("ho_fire_mask", quiet_mask, 0);
    drive(3'b000, 3'b000); step(); step();
    check("ho_fire_idle", network_idle, 0);
    drive(3'b011, 3'b000); step();
    check("partial_mask", quiet_mask, 3'b011);
    drive(3'b000, 3'b000); step(); step(); step();
    check("partial_idle", network_idle, 0);
    drive(3'b100, 3'b000); step();
    drive(3'b000, 3'b000); step();
    check("round2_hold", network_idle, 0);
    step();
    check("round2_idle", network_idle, 1);
`ifdef NETWORK_IDLE_STATS_EN
    check("st_fire2", fire_count, 2);
    check("st_q2", quiesce_count, 2);
`endif

    // same cycle quiet + fire: fire wins
    drive(3'b011, 3'b010); step();
    check("mix_mask", quiet_mask, 0);
    check("mix_idle", network_idle, 0);

    // start coincident with all-quiet dones: dones dropped
    drive(3'b111, 3'b000); ap_start = 1'b1; step(); ap_start = 1'b0;
    check("startq_mask", quiet_mask, 0);
`ifdef NETWORK_IDLE_STATS_EN
    check("st_fire_clr", fire_count, 0);
    check("st_q_clr", quiesce_count, 0);
`endif
    drive(3'b000, 3'b000); step();
    check("startq_mask2", quiet_mask, 0);

    // start while quiescent
    drive(3'b111, 3'b000); step();
    drive(3'b000, 3'b000); step(); step();
    check("pre_start_idle", network_idle, 1);
    ap_start = 1'b1; step(); ap_start = 1'b0;
    check("qstart_idle", network_idle, 0);
    check("qstart_mask", quiet_mask, 0);

    // reset while quiescent, then IDLE ignores dones
    drive(3'b111, 3'b000); step();
    drive(3'b000, 3'b000); step(); step();
    check("pre_rst_idle", network_idle, 1);
    drive(3'b111, 3'b000); ap_rst = 1'b1; step(); ap_rst = 1'b0;
    check("midrst_idle", network_idle, 0);
    check("midrst_mask", quiet_mask, 0);
    step();
    check("postrst_mask", quiet_mask, 0);
    check("postrst_idle", network_idle, 0);
    drive(3'b000, 3'b000);

    // HOLDOFF=0 instance: idle the cycle after the last quiet bit
    ap_start = 1'b1; step(); ap_start = 1'b0;
    d0_done = 3'b011; d0_exec = 3'b000; step();
    check("h0_mask", d0_mask, 3'b011);
    check("h0_pre_idle", d0_idle, 0);
    d0_done = 3'b100; step();
    check("h0_idle", d0_idle, 1);
    d0_done = 3'b001; d0_exec = 3'b001; step();
    check("h0_fire_idle", d0_idle, 0);
    check("h0_fire_mask", d0_mask, 0);
    d0_done = 3'b000; d0_exec = 3'b000; step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/network_idle_detector.md
Name: network_idle_detector

Overview:
- Aggregates completion reports from all actor triggers in a dataflow network and produces the registered `network_idle` flag that each trigger samples when deciding whether to finish or sleep.
- Sits upstream of every trigger instance, fed by each trigger's actor done/return pair.
- Declares quiescence only after every actor has completed at least one invocation without executing since the last firing anywhere in the network, followed by a stability hold-off.

Parameters:
- NUM_ACTORS, 4, number of actor triggers monitored (1..64).
- HOLDOFF, 2, extra cycles the all-quiet condition must persist before `network_idle` rises (0..255).

Ports:
- ap_clk  input  1  clock.
- ap_rst  input  1  synchronous reset, active-high.
- ap_start  input  1  network-level start pulse; begins a new tracking run.
- actor_done  input  NUM_ACTORS  bit i: actor i completed an invocation this cycle (single-cycle pulse).
- actor_executed  input  NUM_ACTORS  bit i: actor i's return code equals EXECUTED; meaningful only when actor_done[i]=1.
- network_idle  output  1  registered; high when the network is quiescent.
- quiet_mask  output  NUM_ACTORS  registered debug view of per-actor quiet bits.

Behaviour:
- Single clock domain, synchronous active-high reset.
- Reset values: state=IDLE, network_idle=0, quiet_mask=0, hold-off counter=0.
- State IDLE: network_idle=0; all done pulses ignored; ap_start=1 -> TRACKING, mask cleared.
- Event classification per cycle:
  - fire = |(actor_done & actor_executed)
  - quiet_set = actor_done & ~actor_executed
- State TRACKING:
  - fire=1: quiet_mask <= 0 and counter <= 0. Fire has priority, so quiet bits presented in the same cycle are also discarded.
  - Else: quiet_mask <= quiet_mask | quiet_set. Bits are sticky; repeated non-executed dones from the same actor are harmless.
  - Mask all-ones and fire=0: counter increments each cycle.
  - When the counter reaches HOLDOFF with fire=0 -> QUIESCENT, network_idle <= 1.
- Latency: if the last missing quiet bit arrives in cycle t with no fire, network_idle is high from cycle t+1+HOLDOFF, provided no fire occurs in cycles t..t+HOLDOFF. HOLDOFF=0 gives network_idle high in cycle t+1.
- State QUIESCENT:
  - network_idle=1.
  - fire=1: network_idle <= 0, mask and counter cleared -> TRACKING. network_idle is low in the next cycle.
  - Non-executed dones keep state unchanged.
- ap_start:
  - In any non-IDLE state, clears mask, counter and network_idle -> TRACKING.
  - Has priority over same-cycle done events, which are dropped.
- Counter saturates at HOLDOFF and never wraps.
- The detector has no exit back to IDLE except reset.
- Reset asserted mid-run: all state returns to reset values next cycle regardless of in-flight dones.
- network_idle is driven only from flops; no combinational path from inputs. Triggers sample it in the same cycle as their own done.
- X on actor_executed is don't-care where actor_done=0.

Optional Feature:
- Macro: NETWORK_IDLE_STATS_EN.
- Defined:
  - Adds output `fire_count` (32 bits): count of cycles with fire=1 since the last ap_start.
  - Adds output `quiesce_count` (16 bits): number of TRACKING->QUIESCENT transitions.
  - Both cleared by reset and by ap_start. Both saturate at all-ones.
- Undefined: both ports and their counters are absent; core behaviour is identical.

Test Plan (NUM_ACTORS=3, HOLDOFF=2 unless stated):
- Reset, then pulse done on all actors while in IDLE -> network_idle stays 0, quiet_mask stays 0.
- ap_start; then non-executed dones for actors 0,1,2 in cycles 5,6,7 -> quiet_mask=3'b111 at cycle 8; network_idle=1 from cycle 10.
- Same as above, but actor 1 fires (executed) in cycle 9 -> mask cleared at cycle 10, network_idle never rises. Quiet bits repeated afterwards lead to idle only after a full new round.
- In QUIESCENT, actor 2 done+executed -> network_idle=0 the next cycle, state TRACKING, quiet_mask=0.
- Same cycle: actor 0 non-executed and actor 1 executed -> quiet_mask=0. Separately, ap_start coincident with all-quiet dones -> mask stays 0.
- HOLDOFF=0: final quiet bit in cycle t -> network_idle=1 in cycle t+1. Assert ap_rst in QUIESCENT -> network_idle=0 and state IDLE the next cycle. With NETWORK_IDLE_STATS_EN, check fire_count and quiesce_count increment and clear accordingly.
